tdpram_param: RTL and testbench

TDPRAM_PARAM -- requirements
Module: tdpram_param

---
 rtl/tdpram_pkg.sv | 19 +
 rtl/tdpram_port_out.sv | 59 +++++
 rtl/tdpram_param.sv | 120 ++++++++++++
 tb/tb_tdpram_param.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tdpram_pkg.sv
// Shared types and defaults for the true dual-port RAM: read-during-write
// mode enum plus default geometry.
package tdpram_pkg;

  typedef enum logic [1:0] {
    RDW_READ_FIRST  = 2'd0,
    RDW_WRITE_FIRST = 2'd1,
    RDW_NO_CHANGE   = 2'd2
  } rdw_mode_e;

  localparam int DEFAULT_DATA_W  = 16;
  localparam int DEFAULT_ADDR_W  = 6;
  localparam int DEFAULT_OUT_REG = 0;

  function automatic int depth_of(input int addr_w);
    return 1 << addr_w;
  endfunction

endpackage

// File: rtl/tdpram_port_out.sv
// Per-port read-data pipeline: one mandatory capture stage, an optional
// second register stage, and a synchronous clear that flushes both.
module tdpram_port_out #(
  parameter int DATA_W  = 16,
  parameter int OUT_REG = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sclr,
  input  logic              in_vld,
  input  logic [DATA_W-1:0] in_data,
  output logic [DATA_W-1:0] dout,
  output logic              vld
);

  logic [DATA_W-1:0] s1_data;
  logic              s1_vld;

  // Data only moves on a valid beat so dout holds across idle cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_data <= '0;
      s1_vld  <= 1'b0;
    end else if (sclr) begin
      s1_data <= '0;
      s1_vld  <= 1'b0;
    end else begin
      s1_vld <= in_vld;
      if (in_vld) s1_data <= in_data;
    end
  end

  generate
    if (OUT_REG != 0) begin : g_reg
      logic [DATA_W-1:0] s2_data;
      logic              s2_vld;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          s2_data <= '0;
          s2_vld  <= 1'b0;
        end else if (sclr) begin
          s2_data <= '0;
          s2_vld  <= 1'b0;
        end else begin
          s2_vld <= s1_vld;
          if (s1_vld) s2_data <= s1_data;
        end
      end

      assign dout = s2_data;
      assign vld  = s2_vld;
    end else begin : g_noreg
      assign dout = s1_data;
      assign vld  = s1_vld;
    end
  endgenerate

endmodule

// File: rtl/tdpram_param.sv
// True dual-port RAM with byte enables, configurable read-during-write
// behaviour, optional output register and cross-port collision flag.
module tdpram_param
  import tdpram_pkg::*;
#(
  parameter int        DATA_W   = DEFAULT_DATA_W,
  parameter int        ADDR_W   = DEFAULT_ADDR_W,
  parameter int        OUT_REG  = DEFAULT_OUT_REG,
  parameter rdw_mode_e RDW_MODE = RDW_READ_FIRST
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                sclr,
  input  logic                en_a,
  input  logic                we_a,
  input  logic [DATA_W/8-1:0] be_a,
  input  logic [ADDR_W-1:0]   addr_a,
  input  logic [DATA_W-1:0]   din_a,
  output logic [DATA_W-1:0]   dout_a,
  output logic                vld_a,
  input  logic                en_b,
  input  logic                we_b,
  input  logic [DATA_W/8-1:0] be_b,
  input  logic [ADDR_W-1:0]   addr_b,
  input  logic [DATA_W-1:0]   din_b,
  output logic [DATA_W-1:0]   dout_b,
  output logic                vld_b,
  output logic                coll
);

  // Handshake: en is an unconditional request (no back-pressure); every
  // accepted access that returns data yields exactly one vld pulse, and dout
  // is meaningful only while vld is high, holding its last value otherwise.

  localparam int NB    = DATA_W / 8;
  localparam int DEPTH = depth_of(ADDR_W);

  logic [DATA_W-1:0] mem [DEPTH];

  logic              acc_a, acc_b;
  logic              wr_a, wr_b;
  logic              ret_a, ret_b;
  logic [DATA_W-1:0] old_a, old_b;
  logic [DATA_W-1:0] rd_word_a, rd_word_b;
  logic              coll_d;

  function automatic logic [DATA_W-1:0] merge_bytes(
    input logic [DATA_W-1:0] old_w,
    input logic [DATA_W-1:0] new_w,
    input logic [NB-1:0]     be
  );
    logic [DATA_W-1:0] res;
    res = old_w;
    for (int i = 0; i < NB; i++) begin
      if (be[i]) res[i*8 +: 8] = new_w[i*8 +: 8];
    end
    return res;
  endfunction

  // Accesses are ignored while reset is held.
  assign acc_a = en_a & rst_n;
  assign acc_b = en_b & rst_n;
  assign wr_a  = acc_a & we_a;
  assign wr_b  = acc_b & we_b;

  // The array is read before this edge's writes land, so a cross-port
  // reader always sees the old word.
  assign old_a = mem[addr_a];
  assign old_b = mem[addr_b];

  assign rd_word_a = (wr_a && RDW_MODE == RDW_WRITE_FIRST) ?
                     merge_bytes(old_a, din_a, be_a) : old_a;
  assign rd_word_b = (wr_b && RDW_MODE == RDW_WRITE_FIRST) ?
                     merge_bytes(old_b, din_b, be_b) : old_b;

  assign ret_a = acc_a & ~(wr_a & (RDW_MODE == RDW_NO_CHANGE));
  assign ret_b = acc_b & ~(wr_b & (RDW_MODE == RDW_NO_CHANGE));

  // Port A is written last so it owns bytes both ports enable on a shared address.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NB; i++) begin
      if (wr_b && be_b[i]) mem[addr_b][i*8 +: 8] <= din_b[i*8 +: 8];
      if (wr_a && be_a[i]) mem[addr_a][i*8 +: 8] <= din_a[i*8 +: 8];
    end
  end

  assign coll_d = acc_a & acc_b & (addr_a == addr_b) & (we_a | we_b);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) coll <= 1'b0;
    else        coll <= coll_d;
  end

  tdpram_port_out #(
    .DATA_W  (DATA_W),
    .OUT_REG (OUT_REG)
  ) u_out_a (
    .clk     (clk),
    .rst_n   (rst_n),
    .sclr    (sclr),
    .in_vld  (ret_a),
    .in_data (rd_word_a),
    .dout    (dout_a),
    .vld     (vld_a)
  );

  tdpram_port_out #(
    .DATA_W  (DATA_W),
    .OUT_REG (OUT_REG)
  ) u_out_b (
    .clk     (clk),
    .rst_n   (rst_n),
    .sclr    (sclr),
    .in_vld  (ret_b),
    .in_data (rd_word_b),
    .dout    (dout_b),
    .vld     (vld_b)
  );

endmodule

// File: tb/tb_tdpram_param.sv
// Bench for tdpram_param: three configurations driven in lockstep, checked
// against a cycle-level behavioural model plus directed literal expectations.
module tb_tdpram_param;
  import tdpram_pkg::*;

  localparam int DW   = 16;
  localparam int AW   = 6;
  localparam int NCFG = 3;
  localparam int LAT [NCFG] = '{1, 2, 1};

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic sclr  = 1'b0;
  always #5 clk = ~clk;

  logic          en_a = 1'b0, we_a = 1'b0, en_b = 1'b0, we_b = 1'b0;
  logic [1:0]    be_a = '0, be_b = '0;
  logic [AW-1:0] addr_a = '0, addr_b = '0;
  logic [DW-1:0] din_a = '0, din_b = '0;

  logic [DW-1:0] dout_a_s [NCFG];
  logic [DW-1:0] dout_b_s [NCFG];
  logic          vld_a_s  [NCFG];
  logic          vld_b_s  [NCFG];
  logic          coll_s   [NCFG];

  tdpram_param #(.DATA_W(DW), .ADDR_W(AW), .OUT_REG(0), .RDW_MODE(RDW_READ_FIRST)) dut_rf (
    .clk(clk), .rst_n(rst_n), .sclr(sclr),
    .en_a(en_a), .we_a(we_a), .be_a(be_a), .addr_a(addr_a), .din_a(din_a),
    .dout_a(dout_a_s[0]), .vld_a(vld_a_s[0]),
    .en_b(en_b), .we_b(we_b), .be_b(be_b), .addr_b(addr_b), .din_b(din_b),
    .dout_b(dout_b_s[0]), .vld_b(vld_b_s[0]), .coll(coll_s[0]));

  tdpram_param #(.DATA_W(DW), .ADDR_W(AW), .OUT_REG(1), .RDW_MODE(RDW_WRITE_FIRST)) dut_wf (
    .clk(clk), .rst_n(rst_n), .sclr(sclr),
    .en_a(en_a), .we_a(we_a), .be_a(be_a), .addr_a(addr_a), .din_a(din_a),
    .dout_a(dout_a_s[1]), .vld_a(vld_a_s[1]),
    .en_b(en_b), .we_b(we_b), .be_b(be_b), .addr_b(addr_b), .din_b(din_b),
    .dout_b(dout_b_s[1]), .vld_b(vld_b_s[1]), .coll(coll_s[1]));

  tdpram_param #(.DATA_W(DW), .ADDR_W(AW), .OUT_REG(0), .RDW_MODE(RDW_NO_CHANGE)) dut_nc (
    .clk(clk), .rst_n(rst_n), .sclr(sclr),
    .en_a(en_a), .we_a(we_a), .be_a(be_a), .addr_a(addr_a), .din_a(din_a),
    .dout_a(dout_a_s[2]), .vld_a(vld_a_s[2]),
    .en_b(en_b), .we_b(we_b), .be_b(be_b), .addr_b(addr_b), .din_b(din_b),
    .dout_b(dout_b_s[2]), .vld_b(vld_b_s[2]), .coll(coll_s[2]));

  // ---------------- scoreboard counters ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic rdw_mode_e cfg_mode(input int c);
    case (c)
      0:       return RDW_READ_FIRST;
      1:       return RDW_WRITE_FIRST;
      default: return RDW_NO_CHANGE;
    endcase
  endfunction

  // ---------------- behavioural model ----------------
  // Each access produces a result at its sampling edge; that result appears
  // LAT edges later unless a clear (reset or sclr) happened in between.
  logic [DW-1:0] mdl_mem  [2**AW];
  logic          hist_v   [NCFG][2][4];
  logic [DW-1:0] hist_d   [NCFG][2][4];
  logic [DW-1:0] exp_dout [NCFG][2];
  logic          exp_vld  [NCFG][2];
  logic          exp_coll = 1'b0;
  int            cyc = 0, kill_cyc = 0, s;

  logic          p_en [2], p_we [2];
  logic [1:0]    p_be [2];
  logic [AW-1:0] p_addr [2];
  logic [DW-1:0] p_din [2], p_old [2], p_new [2];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      kill_cyc = cyc;
      exp_coll = 1'b0;
      for (int c = 0; c < NCFG; c++)
        for (int p = 0; p < 2; p++) begin
          exp_dout[c][p] = '0;
          exp_vld[c][p]  = 1'b0;
        end
    end else begin
      cyc++;
      p_en[0] = en_a;  p_we[0] = we_a;  p_be[0] = be_a;  p_addr[0] = addr_a;  p_din[0] = din_a;
      p_en[1] = en_b;  p_we[1] = we_b;  p_be[1] = be_b;  p_addr[1] = addr_b;  p_din[1] = din_b;
      for (int p = 0; p < 2; p++) begin
        p_old[p] = mdl_mem[p_addr[p]];
        p_new[p] = p_old[p];
        for (int b = 0; b < 2; b++)
          if (p_be[p][b]) p_new[p][b*8 +: 8] = p_din[p][b*8 +: 8];
      end
      for (int c = 0; c < NCFG; c++)
        for (int p = 0; p < 2; p++) begin
          hist_v[c][p][cyc%4] = p_en[p] && !(p_we[p] && cfg_mode(c) == RDW_NO_CHANGE);
          hist_d[c][p][cyc%4] = (p_we[p] && cfg_mode(c) == RDW_WRITE_FIRST) ? p_new[p] : p_old[p];
        end
      for (int b = 0; b < 2; b++) begin
        if (en_b && we_b && be_b[b] && !(en_a && we_a && be_a[b] && addr_a == addr_b))
          mdl_mem[addr_b][b*8 +: 8] = din_b[b*8 +: 8];
        if (en_a && we_a && be_a[b])
          mdl_mem[addr_a][b*8 +: 8] = din_a[b*8 +: 8];
      end
      exp_coll = en_a && en_b && (addr_a == addr_b) && (we_a || we_b);
      if (sclr) begin
        kill_cyc = cyc;
        for (int c = 0; c < NCFG; c++)
          for (int p = 0; p < 2; p++) begin
            exp_dout[c][p] = '0;
            exp_vld[c][p]  = 1'b0;
          end
      end else begin
        for (int c = 0; c < NCFG; c++)
          for (int p = 0; p < 2; p++) begin
            s = cyc - LAT[c] + 1;
            if (s > kill_cyc && hist_v[c][p][s%4]) begin
              exp_vld[c][p]  = 1'b1;
              exp_dout[c][p] = hist_d[c][p][s%4];
            end else begin
              exp_vld[c][p] = 1'b0;
            end
          end
      end
    end
  end

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    for (int c = 0; c < NCFG; c++) begin
      check($sformatf("cfg%0d dout_a", c), {16'b0, dout_a_s[c]}, {16'b0, exp_dout[c][0]});
      check($sformatf("cfg%0d vld_a", c),  {31'b0, vld_a_s[c]},  {31'b0, exp_vld[c][0]});
      check($sformatf("cfg%0d dout_b", c), {16'b0, dout_b_s[c]}, {16'b0, exp_dout[c][1]});
      check($sformatf("cfg%0d vld_b", c),  {31'b0, vld_b_s[c]},  {31'b0, exp_vld[c][1]});
      check($sformatf("cfg%0d coll", c),   {31'b0, coll_s[c]},   {31'b0, exp_coll});
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic idle();
    en_a = 1'b0; we_a = 1'b0; en_b = 1'b0; we_b = 1'b0; sclr = 1'b0;
  endtask

  task automatic set_a(input logic en, input logic we, input logic [1:0] be,
                       input logic [AW-1:0] addr, input logic [DW-1:0] din);
    en_a = en; we_a = we; be_a = be; addr_a = addr; din_a = din;
  endtask

  task automatic set_b(input logic en, input logic we, input logic [1:0] be,
                       input logic [AW-1:0] addr, input logic [DW-1:0] din);
    en_b = en; we_b = we; be_b = be; addr_b = addr; din_b = din;
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    idle();
    repeat (2) @(posedge clk);
    #2;
    for (int c = 0; c < NCFG; c++) begin
      check("reset dout_a", {16'b0, dout_a_s[c]}, 32'h0);
      check("reset vld_a",  {31'b0, vld_a_s[c]},  32'h0);
      check("reset coll",   {31'b0, coll_s[c]},   32'h0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Fill the whole address range, then read it back from both ports.
    for (int i = 0; i < 32; i++) begin
      set_a(1'b1, 1'b1, 2'b11, AW'(2*i),   DW'($urandom));
      set_b(1'b1, 1'b1, 2'b11, AW'(2*i+1), DW'($urandom));
      tick();
    end
    for (int i = 0; i < 64; i++) begin
      set_a(1'b1, 1'b0, 2'b11, AW'(i),    '0);
      set_b(1'b1, 1'b0, 2'b00, AW'(63-i), '0);
      tick();
    end
    idle(); tick(); tick();

    // Write A then read B, latency 1 and 2.
    set_a(1'b1, 1'b1, 2'b11, 6'h05, 16'hBEEF); tick();
    idle(); set_b(1'b1, 1'b0, 2'b11, 6'h05, '0); tick();
    check("r032 rf dout_b", {16'b0, dout_b_s[0]}, 32'hBEEF);
    check("r032 rf vld_b",  {31'b0, vld_b_s[0]},  32'h1);
    check("r032 wf vld_b early", {31'b0, vld_b_s[1]}, 32'h0);
    idle(); tick();
    check("r032 wf dout_b", {16'b0, dout_b_s[1]}, 32'hBEEF);
    check("r032 wf vld_b",  {31'b0, vld_b_s[1]},  32'h1);
    check("r032 rf hold dout_b", {16'b0, dout_b_s[0]}, 32'hBEEF);
    check("r032 rf idle vld_b",  {31'b0, vld_b_s[0]},  32'h0);

    // Byte-enable merge and an all-zero byte enable.
    set_a(1'b1, 1'b1, 2'b11, 6'h3F, 16'h1234); tick();
    check("plain write rf vld_a", {31'b0, vld_a_s[0]}, 32'h1);
    set_a(1'b1, 1'b1, 2'b10, 6'h3F, 16'hAB00); tick();
    set_a(1'b1, 1'b0, 2'b11, 6'h3F, '0); tick();
    check("r033 merged", {16'b0, dout_a_s[0]}, 32'hAB34);
    set_a(1'b1, 1'b1, 2'b00, 6'h3F, 16'hFFFF); tick();
    set_a(1'b1, 1'b0, 2'b11, 6'h3F, '0); tick();
    check("be zero no change", {16'b0, dout_a_s[0]}, 32'hAB34);
    idle(); tick();

    // Read/write collision and per-mode own-port behaviour.
    set_a(1'b1, 1'b1, 2'b11, 6'h10, 16'h1111); tick();
    set_a(1'b1, 1'b1, 2'b11, 6'h10, 16'h2222);
    set_b(1'b1, 1'b0, 2'b11, 6'h10, '0); tick();
    check("r034 rf dout_b", {16'b0, dout_b_s[0]}, 32'h1111);
    check("r034 rf dout_a", {16'b0, dout_a_s[0]}, 32'h1111);
    check("r034 nc vld_a",  {31'b0, vld_a_s[2]},  32'h0);
    for (int c = 0; c < NCFG; c++) check("r034 coll", {31'b0, coll_s[c]}, 32'h1);
    idle(); tick();
    check("r034 wf dout_a", {16'b0, dout_a_s[1]}, 32'h2222);
    check("r034 wf vld_a",  {31'b0, vld_a_s[1]},  32'h1);
    check("r034 wf dout_b", {16'b0, dout_b_s[1]}, 32'h1111);
    check("r034 coll drops", {31'b0, coll_s[1]},  32'h0);
    set_a(1'b1, 1'b0, 2'b11, 6'h10, '0); tick();
    check("r034 readback", {16'b0, dout_a_s[0]}, 32'h2222);

    // Write/write collision.
    set_a(1'b1, 1'b1, 2'b01, 6'h20, 16'hAAAA);
    set_b(1'b1, 1'b1, 2'b11, 6'h20, 16'hBBBB); tick();
    check("r035 coll", {31'b0, coll_s[0]}, 32'h1);
    idle(); set_b(1'b1, 1'b0, 2'b11, 6'h20, '0); tick();
    check("r035 merged", {16'b0, dout_b_s[0]}, 32'hBBAA);
    set_a(1'b1, 1'b1, 2'b11, 6'h21, 16'h1234);
    set_b(1'b1, 1'b1, 2'b11, 6'h21, 16'h5678); tick();
    idle(); set_b(1'b1, 1'b0, 2'b11, 6'h21, '0); tick();
    check("ww full A wins", {16'b0, dout_b_s[0]}, 32'h1234);
    set_a(1'b1, 1'b0, 2'b11, 6'h20, '0);
    set_b(1'b1, 1'b0, 2'b11, 6'h20, '0); tick();
    idle(); tick();
    check("rr no coll", {31'b0, coll_s[0]}, 32'h0);

    // Asynchronous reset with reads in flight.
    set_a(1'b1, 1'b0, 2'b11, 6'h05, '0);
    set_b(1'b1, 1'b0, 2'b11, 6'h10, '0); tick();
    idle();
    #1 rst_n = 1'b0;
    #1;
    check("r036 rst wf dout_a", {16'b0, dout_a_s[1]}, 32'h0);
    check("r036 rst wf vld_a",  {31'b0, vld_a_s[1]},  32'h0);
    check("r036 rst rf dout_b", {16'b0, dout_b_s[0]}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("r036 rst dropped", {31'b0, vld_a_s[1]}, 32'h0);
    set_a(1'b1, 1'b0, 2'b11, 6'h05, '0);
    set_b(1'b1, 1'b0, 2'b11, 6'h10, '0); tick();
    check("r036 rst kept a", {16'b0, dout_a_s[0]}, 32'hBEEF);
    check("r036 rst kept b", {16'b0, dout_b_s[0]}, 32'h2222);
    idle(); tick(); tick();

    // Synchronous clear with reads in flight and a write in the clear cycle.
    set_a(1'b1, 1'b0, 2'b11, 6'h05, '0);
    set_b(1'b1, 1'b0, 2'b11, 6'h10, '0); tick();
    idle(); sclr = 1'b1;
    set_a(1'b1, 1'b1, 2'b11, 6'h3F, 16'h5A5A); tick();
    check("r036 sclr wf dout_a", {16'b0, dout_a_s[1]}, 32'h0);
    check("r036 sclr wf vld_a",  {31'b0, vld_a_s[1]},  32'h0);
    check("r036 sclr rf dout_a", {16'b0, dout_a_s[0]}, 32'h0);
    idle(); tick();
    check("r036 sclr flushed", {31'b0, vld_b_s[1]}, 32'h0);
    set_a(1'b1, 1'b0, 2'b11, 6'h3F, '0);
    set_b(1'b1, 1'b0, 2'b11, 6'h05, '0); tick();
    check("r036 sclr write kept", {16'b0, dout_a_s[0]}, 32'h5A5A);
    check("r036 sclr mem kept",   {16'b0, dout_b_s[0]}, 32'hBEEF);
    idle();
    repeat (4) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
